// File: rtl/ir_pkg.sv
// ir_pkg: shared NEC IR definitions for ir_encoder and ir_decoder.
//   ir_tx_state_t   transmitter state encoding
//   *_U localparams durations of each NEC element, in NEC units (562.5 us)
//   is_mark_state() true for states in which the LED carrier is on
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } ir_tx_state_t;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int REP_SPACE_U  = 4;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_U       = 1;

  function automatic logic is_mark_state(input ir_tx_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_encoder_carrier_gen.sv
// ir_carrier_gen: phase-restartable square wave for IR LED modulation.
//   clk      system clock
//   rst      synchronous active-high reset
//   restart  on this edge the wave restarts high with a full half period
//   en       gates the output (carrier is 0 while en is low)
//   carrier  gated square wave, half period HALF clock cycles
module ir_carrier_gen #(
  parameter int HALF = 328
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic carrier
);

  localparam int CW = (HALF > 1) ? $clog2(HALF + 1) : 1;

  logic [CW-1:0] cnt_reg;
  logic          phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b1;
    end else if (cnt_reg == CW'(HALF - 1)) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign carrier = en & phase_reg;

endmodule

// File: rtl/ir_encoder.sv
// ir_encoder: NEC-format IR transmitter (32-bit command, LSB first).
//   clk          system clock
//   rst          synchronous active-high reset (aborts any frame, no done)
//   enable       gates acceptance of new requests only
//   start        request a full frame (wins over repeat_req)
//   repeat_req   request an NEC repeat code
//   command      frame payload, bit 0 sent first; latched on accept
//   ready        high only while idle
//   busy         complement of ready
//   done         one-cycle pulse as the transmitter returns to idle
//   ir_envelope  unmodulated mark signal (1 = mark)
//   ir_out       envelope modulated with the carrier, drives the LED
module ir_encoder
  import ir_pkg::*;
#(
  parameter int clk_hz     = 25000000,
  parameter int carrier_hz = 38000,
  parameter int gap_units  = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic        repeat_req,
  input  logic [31:0] command,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        ir_envelope,
  output logic        ir_out
);

  localparam int UNIT_CYCLES  = clk_hz * 9 / 16000;
  localparam int CARRIER_HALF = clk_hz / (2 * carrier_hz);
  localparam int CYC_W        = $clog2(UNIT_CYCLES + 1);
  localparam int MAX_UNITS    = (gap_units > LEAD_MARK_U) ? gap_units : LEAD_MARK_U;
  localparam int UNIT_W       = $clog2(MAX_UNITS + 1);

  ir_tx_state_t      state_reg, state_next;
  logic [CYC_W-1:0]  cyc_reg;
  logic [UNIT_W-1:0] unit_reg;
  logic [4:0]        bit_idx_reg;
  logic [31:0]       cmd_reg;
  logic              rep_reg;
  logic              env_reg;
  logic              done_reg;

  logic              accept;
  logic              advance;
  logic              done_next;
  logic              cyc_last;
  logic [UNIT_W-1:0] unit_last;
  logic              carrier_w;

  assign cyc_last = (cyc_reg == CYC_W'(UNIT_CYCLES - 1));

  // Index of the final unit of the current state.
  always_comb begin
    unit_last = '0;
    case (state_reg)
      LEAD_MARK:  unit_last = UNIT_W'(LEAD_MARK_U - 1);
      LEAD_SPACE: unit_last = rep_reg ? UNIT_W'(REP_SPACE_U - 1) : UNIT_W'(LEAD_SPACE_U - 1);
      BIT_MARK:   unit_last = UNIT_W'(BIT_MARK_U - 1);
      BIT_SPACE:  unit_last = cmd_reg[bit_idx_reg] ? UNIT_W'(ONE_SPACE_U - 1)
                                                   : UNIT_W'(ZERO_SPACE_U - 1);
      STOP_MARK:  unit_last = UNIT_W'(STOP_U - 1);
      GAP:        unit_last = UNIT_W'(gap_units - 1);
      default:    unit_last = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    advance    = 1'b0;
    done_next  = 1'b0;
    if (state_reg == IDLE) begin
      if (enable && (start || repeat_req)) begin
        accept     = 1'b1;
        state_next = LEAD_MARK;
      end
    end else if (cyc_last && (unit_reg == unit_last)) begin
      advance = 1'b1;
      case (state_reg)
        LEAD_MARK:  state_next = LEAD_SPACE;
        LEAD_SPACE: state_next = rep_reg ? STOP_MARK : BIT_MARK;
        BIT_MARK:   state_next = BIT_SPACE;
        BIT_SPACE:  state_next = (bit_idx_reg == 5'd31) ? STOP_MARK : BIT_MARK;
        STOP_MARK:  state_next = GAP;
        GAP: begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cyc_reg     <= '0;
      unit_reg    <= '0;
      bit_idx_reg <= '0;
      cmd_reg     <= '0;
      rep_reg     <= 1'b0;
      env_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      // Registered envelope follows the next state so the mark is visible
      // from the cycle right after the accept edge.
      env_reg   <= is_mark_state(state_next);
      if (accept) begin
        cmd_reg     <= command;
        rep_reg     <= ~start;
        bit_idx_reg <= '0;
        cyc_reg     <= '0;
        unit_reg    <= '0;
      end else if (advance) begin
        cyc_reg  <= '0;
        unit_reg <= '0;
        // 5-bit index wraps 31 -> 0 as bit 31's space ends.
        if (state_reg == BIT_SPACE) bit_idx_reg <= bit_idx_reg + 1'b1;
      end else if (state_reg != IDLE) begin
        if (cyc_last) begin
          cyc_reg  <= '0;
          unit_reg <= unit_reg + 1'b1;
        end else begin
          cyc_reg <= cyc_reg + 1'b1;
        end
      end
    end
  end

  // Carrier restarts on the same edge that enters any mark state.
  ir_carrier_gen #(
    .HALF (CARRIER_HALF)
  ) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart ((accept || advance) && is_mark_state(state_next)),
    .en      (env_reg),
    .carrier (carrier_w)
  );

  assign ready       = (state_reg == IDLE);
  assign busy        = ~ready;
  assign done        = done_reg;
  assign ir_envelope = env_reg;
  assign ir_out      = env_reg & carrier_w;

endmodule

// File: tb/tb_ir_encoder.sv
module tb_ir_encoder;

  localparam int CLK_HZ = 16000;
  localparam int CAR_HZ = 2000;
  localparam int GAP_U  = 4;
  localparam int UNIT   = 9;
  localparam int HALF   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start;
  logic        repeat_req;
  logic [31:0] command;
  logic        ready, busy, done, ir_envelope, ir_out;

  int checks = 0;
  int errors = 0;

  bit exp_env[$];
  bit obs_env[$];
  int exp_active;

  always #5 clk = ~clk;

  ir_encoder #(
    .clk_hz     (CLK_HZ),
    .carrier_hz (CAR_HZ),
    .gap_units  (GAP_U)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .repeat_req  (repeat_req),
    .command     (command),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .ir_envelope (ir_envelope),
    .ir_out      (ir_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the NEC envelope as a per-cycle list of levels.
  function automatic void push_run(input bit lvl, input int units);
    for (int k = 0; k < units * UNIT; k++) exp_env.push_back(lvl);
  endfunction

  function automatic void build_model(input logic [31:0] cmd, input bit rep);
    exp_env.delete();
    push_run(1'b1, 16);
    push_run(1'b0, rep ? 4 : 8);
    if (!rep) begin
      for (int b = 0; b < 32; b++) begin
        push_run(1'b1, 1);
        push_run(1'b0, cmd[b] ? 3 : 1);
      end
    end
    push_run(1'b1, 1);
    exp_active = exp_env.size();
    push_run(1'b0, GAP_U);
  endfunction

  // Receiver-side decode of the observed envelope by run lengths.
  function automatic logic [31:0] decode_obs();
    int runs[$];
    int len;
    logic [31:0] d;
    d = 'x;
    len = 1;
    for (int i = 1; i < obs_env.size(); i++) begin
      if (obs_env[i] == obs_env[i-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    runs.push_back(len);
    if (runs.size() >= 68) begin
      for (int b = 0; b < 32; b++) d[b] = (runs[3 + 2*b] > 2 * UNIT);
    end
    return d;
  endfunction

  // Issue one request and check every cycle of the resulting transmission.
  // poke >= 0 pulses start at that cycle and then drops enable briefly.
  task automatic run_frame(input logic [31:0] cmd, input bit st, input bit rp, input int poke);
    int n, env_err, out_err, rdy_err, k, last_hi, idle_err;
    bit exp_out;
    build_model(cmd, rp && !st);
    n = exp_env.size();
    env_err = 0; out_err = 0; rdy_err = 0; k = 0; last_hi = 0; idle_err = 0;
    obs_env.delete();
    @(negedge clk);
    command = cmd; start = st; repeat_req = rp;
    @(negedge clk);
    start = 1'b0; repeat_req = 1'b0; command = $urandom;
    for (int i = 0; i < n; i++) begin
      if (exp_env[i] && (i == 0 || !exp_env[i-1])) k = 0;
      exp_out = exp_env[i] && (((k / HALF) % 2) == 0);
      k++;
      if (ir_envelope !== exp_env[i]) env_err++;
      if (ir_out !== exp_out) out_err++;
      if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) rdy_err++;
      obs_env.push_back(ir_envelope === 1'b1);
      if (ir_envelope === 1'b1) last_hi = i + 1;
      if (i == poke) start = 1'b1;
      if (i == poke + 1) begin start = 1'b0; enable = 1'b0; end
      if (i == poke + 20) enable = 1'b1;
      @(negedge clk);
    end
    check("env_pattern", env_err, 0);
    check("carrier_pattern", out_err, 0);
    check("busy_during_frame", rdy_err, 0);
    check("active_len", last_hi, exp_active);
    check("done_pulse", done, 1);
    check("ready_at_done", ready, 1);
    check("busy_at_done", busy, 0);
    if (st) check("decoded_cmd", decode_obs(), cmd);
    @(negedge clk);
    check("done_clear", done, 0);
    for (int i = 0; i < 20; i++) begin
      if (ready !== 1'b1 || ir_envelope !== 1'b0 || ir_out !== 1'b0) idle_err++;
      @(negedge clk);
    end
    check("idle_after_frame", idle_err, 0);
    enable = 1'b1;
    $display("frame cmd=%08h st=%0d rep=%0d poke=%0d cycles=%0d active=%0d",
             cmd, st, rp, poke, n, exp_active);
  endtask

  // Reset during the space of bit 10, then send a fresh frame.
  task automatic reset_mid(input logic [31:0] cmd);
    int c0, done_seen;
    c0 = 216;
    for (int b = 0; b < 10; b++) c0 += 9 + (cmd[b] ? 27 : 9);
    c0 += 9 + 1;
    done_seen = 0;
    @(negedge clk);
    command = cmd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (c0) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ir_out", ir_out, 0);
    check("rst_mid_env", ir_envelope, 0);
    check("rst_mid_ready", ready, 1);
    check("rst_mid_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || ready !== 1'b1) done_seen++;
      @(negedge clk);
    end
    check("rst_mid_quiet", done_seen, 0);
    $display("reset_mid cmd=%08h at_cycle=%0d", cmd, c0);
    run_frame($urandom, 1'b1, 1'b0, -1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; start = 1'b0; repeat_req = 1'b0; command = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_env", ir_envelope, 0);
    check("rst_ir_out", ir_out, 0);

    run_frame(32'h0000_0000, 1'b1, 1'b0, -1);
    run_frame(32'h00FF_00FF, 1'b1, 1'b0, -1);
    run_frame(32'h1234_5678, 1'b0, 1'b1, -1);
    run_frame($urandom, 1'b1, 1'b1, -1);
    run_frame($urandom, 1'b1, 1'b0, 300);

    // start with enable low: not accepted, not queued.
    @(negedge clk);
    enable = 1'b0; start = 1'b1; command = $urandom;
    repeat (3) @(negedge clk);
    check("en0_ready", ready, 1);
    check("en0_env", ir_envelope, 0);
    start = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("en0_not_queued", ready, 1);
    $display("enable_low start ignored");

    reset_mid($urandom);
    run_frame(32'hA55A_1EE1, 1'b1, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      bit rp;
      rp = ($urandom_range(0, 3) == 0);
      run_frame($urandom, !rp, rp, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
